// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE psum output stage: FSM state encoding,
// config field widths and saturation limits derived from the stored psum width.
package pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } pe_state_e;

  localparam int KSIZE_W   = 3;
  localparam int SHIFT_W   = 3;
  localparam int KSIZE_MIN = 1;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/psum_bank.sv
// One psum bank: 1R1W memory with a registered read port; rdata holds while
// no read is issued, which the drain path relies on during backpressure.
module psum_bank #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // write port and synchronous read port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/pe_psum_accum.sv
// PE output stage: splits column psums into two lanes, accumulates each lane
// into its own bank over several passes, then drains both banks downstream.
module pe_psum_accum
  import pe_pkg::*;
#(
  parameter int COLUMN_NUM     = 6,
  parameter int COL_PSUM_WIDTH = 19,
  parameter int PDATA_WIDTH    = 16,
  parameter int ACC_WIDTH      = 24,
  parameter int BIAS_WIDTH     = 8,
  parameter int DEPTH          = 64,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_cfg_start,
  input  logic [KSIZE_W-1:0]                   i_cfg_ksize,
  input  logic [AW:0]                          i_cfg_len,
  input  logic                                 i_cfg_first,
  input  logic                                 i_cfg_last,
  input  logic [SHIFT_W-1:0]                   i_cfg_shift,
  input  logic [BIAS_WIDTH-1:0]                i_bias,
  input  logic                                 i_in_valid,
  output logic                                 o_in_ready,
  input  logic [COLUMN_NUM*COL_PSUM_WIDTH-1:0] i_psum_column,
  input  logic [2:0]                           i_wgt_shift,
  output logic                                 o_out_valid,
  input  logic                                 i_out_ready,
  output logic [PDATA_WIDTH-1:0]               o_out_data0,
  output logic [PDATA_WIDTH-1:0]               o_out_data1,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(PDATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(PDATA_WIDTH));
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  pe_state_e state_r;
  logic [AW:0] cnt_r, len_r;
  logic [3:0] ksize_r, ksize_clamp_s;
  logic first_r, last_r, in_ready_r, out_valid_r, busy_r, done_r, pv_r;
  logic [SHIFT_W-1:0] shift_r;
  logic signed [BIAS_WIDTH-1:0] bias_r;
  logic [PDATA_WIDTH-1:0] out_data0_r, out_data1_r;
  logic v1_r;
  logic [AW-1:0] addr1_r, raddr_s;
  logic signed [ACC_WIDTH-1:0] sum0_s, sum1_s, sum0_r, sum1_r, col_s;
  logic signed [ACC_WIDTH-1:0] acc0_s, acc1_s, sh0_s, sh1_s;
  logic [PDATA_WIDTH-1:0] rd0_s, rd1_s, wdata0_s, wdata1_s;
  logic accept_s, can_adv_s, issue_s, re_s;

  function automatic logic [PDATA_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
    if (v > SAT_HI) return SAT_HI[PDATA_WIDTH-1:0];
    else if (v < SAT_LO) return SAT_LO[PDATA_WIDTH-1:0];
    else return v[PDATA_WIDTH-1:0];
  endfunction

  // clamp requested kernel width into 1..COLUMN_NUM
  always_comb begin
    if (i_cfg_ksize == 3'd0) ksize_clamp_s = 4'(KSIZE_MIN);
    else if ({1'b0, i_cfg_ksize} > 4'(COLUMN_NUM)) ksize_clamp_s = 4'(COLUMN_NUM);
    else ksize_clamp_s = {1'b0, i_cfg_ksize};
  end

  // lane split: active columns below wgt_shift go to lane0, the rest to lane1
  always_comb begin
    sum0_s = '0;
    sum1_s = '0;
    col_s  = '0;
    for (int j = 0; j < COLUMN_NUM; j++) begin
      col_s = ACC_WIDTH'(signed'(i_psum_column[j*COL_PSUM_WIDTH +: COL_PSUM_WIDTH]));
      if (4'(j) < ksize_r) begin
        if (4'(j) < {1'b0, i_wgt_shift}) sum0_s = sum0_s + col_s;
        else sum1_s = sum1_s + col_s;
      end else begin
        sum0_s = sum0_s;
      end
    end
  end

  assign accept_s  = in_ready_r & i_in_valid;
  assign can_adv_s = !out_valid_r || i_out_ready;
  assign issue_s   = (state_r == ST_DRAIN) && (cnt_r < len_r) && (!pv_r || can_adv_s);
  assign re_s      = accept_s | issue_s;
  assign raddr_s   = cnt_r[AW-1:0];

  // read-modify-write second stage: combine stored psum or bias, shift, saturate
  always_comb begin
    acc0_s = (first_r ? {ACC_WIDTH{1'b0}} : (ACC_WIDTH'(signed'(rd0_s)) <<< shift_r)) + sum0_r;
    acc1_s = (first_r ? ACC_WIDTH'(bias_r) : (ACC_WIDTH'(signed'(rd1_s)) <<< shift_r)) + sum1_r;
    sh0_s  = acc0_s >>> shift_r;
    sh1_s  = acc1_s >>> shift_r;
    wdata0_s = saturate(sh0_s);
    wdata1_s = saturate(sh1_s);
  end

  psum_bank #(.DEPTH(DEPTH), .WIDTH(PDATA_WIDTH), .AW(AW)) u_bank0 (
    .clk(i_clk), .we(v1_r), .waddr(addr1_r), .wdata(wdata0_s),
    .re(re_s), .raddr(raddr_s), .rdata(rd0_s)
  );

  psum_bank #(.DEPTH(DEPTH), .WIDTH(PDATA_WIDTH), .AW(AW)) u_bank1 (
    .clk(i_clk), .we(v1_r), .waddr(addr1_r), .wdata(wdata1_s),
    .re(re_s), .raddr(raddr_s), .rdata(rd1_s)
  );

  // accumulate pipeline stage register; reset drops any write in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_r    <= 1'b0;
      addr1_r <= '0;
      sum0_r  <= '0;
      sum1_r  <= '0;
    end else begin
      v1_r    <= accept_s;
      addr1_r <= cnt_r[AW-1:0];
      sum0_r  <= sum0_s;
      sum1_r  <= sum1_s;
    end
  end

  // control FSM with registered handshake and status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      len_r       <= '0;
      ksize_r     <= 4'(KSIZE_MIN);
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      shift_r     <= '0;
      bias_r      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data0_r <= '0;
      out_data1_r <= '0;
      pv_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_cfg_start) begin
            ksize_r <= ksize_clamp_s;
            len_r   <= i_cfg_len;
            first_r <= i_cfg_first;
            last_r  <= i_cfg_last;
            shift_r <= i_cfg_shift;
            bias_r  <= i_bias;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            if (i_cfg_len == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= ST_ACCUM;
              in_ready_r <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (accept_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r + CNT_ONE == len_r) begin
              in_ready_r <= 1'b0;
              state_r    <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          cnt_r <= '0;
          if (last_r) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (issue_s) cnt_r <= cnt_r + CNT_ONE;
          pv_r <= issue_s | (pv_r & !can_adv_s);
          if (can_adv_s) begin
            out_valid_r <= pv_r;
            if (pv_r) begin
              out_data0_r <= rd0_s;
              out_data1_r <= rd1_s;
            end
          end
          if (out_valid_r && i_out_ready && !pv_r && cnt_r == len_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = in_ready_r;
  assign o_out_valid = out_valid_r;
  assign o_out_data0 = out_data0_r;
  assign o_out_data1 = out_data1_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;

endmodule

// File: tb/tb_pe_psum_accum.sv
// Directed bench for pe_psum_accum: table of single-pass vectors plus
// hand-written sequences for backpressure, len=0, busy-start and reset.
module tb_pe_psum_accum;

  localparam int COLS = 6, CW = 19, PW = 16, BW = 8, DEPTH = 64, AW = 6;
  localparam int BUS = COLS * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_rst, i_cfg_start, i_cfg_first, i_cfg_last, i_in_valid, i_out_ready;
  logic [2:0] i_cfg_ksize, i_cfg_shift, i_wgt_shift;
  logic [AW:0] i_cfg_len;
  logic [BW-1:0] i_bias;
  logic [BUS-1:0] i_psum_column;
  logic o_in_ready, o_out_valid, o_busy, o_done;
  logic [PW-1:0] o_out_data0, o_out_data1;

  pe_psum_accum dut (
    .i_clk(clk), .i_rst(i_rst), .i_cfg_start(i_cfg_start), .i_cfg_ksize(i_cfg_ksize),
    .i_cfg_len(i_cfg_len), .i_cfg_first(i_cfg_first), .i_cfg_last(i_cfg_last),
    .i_cfg_shift(i_cfg_shift), .i_bias(i_bias), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_psum_column(i_psum_column), .i_wgt_shift(i_wgt_shift),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data0(o_out_data0),
    .o_out_data1(o_out_data1), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    logic [2:0]     k;
    logic [2:0]     w;
    logic           f;
    logic [2:0]     s;
    logic [7:0]     b;
    logic [BUS-1:0] cols;
    logic [15:0]    e0;
    logic [15:0]    e1;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] exp0_q[$];
  logic [15:0] exp1_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always @(posedge clk) if (o_done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BUS-1:0] pack6(input int c0, c1, c2, c3, c4, c5);
    int c [6];
    logic [31:0] t;
    logic [BUS-1:0] r;
    c = '{c0, c1, c2, c3, c4, c5};
    r = '0;
    for (int j = 0; j < COLS; j++) begin
      t = c[j];
      r[j*CW +: CW] = t[CW-1:0];
    end
    return r;
  endfunction

  task automatic add_vec(input int k, w, f, s, b, input logic [BUS-1:0] cols, input int e0, e1);
    vec_t v;
    v.k = 3'(k); v.w = 3'(w); v.f = 1'(f); v.s = 3'(s); v.b = 8'(b);
    v.cols = cols; v.e0 = 16'(e0); v.e1 = 16'(e1);
    tbl.push_back(v);
  endtask

  task automatic start_pass(input logic [2:0] k, input logic [AW:0] len, input logic f, l,
                            input logic [2:0] s, input logic [7:0] b);
    i_cfg_ksize = k; i_cfg_len = len; i_cfg_first = f; i_cfg_last = l;
    i_cfg_shift = s; i_bias = b; i_cfg_start = 1'b1;
    @(posedge clk); #1;
    i_cfg_start = 1'b0;
  endtask

  task automatic feed_beat(input logic [BUS-1:0] cols, input logic [2:0] wgt);
    int t;
    bit got;
    t = 0; got = 1'b0;
    i_psum_column = cols; i_wgt_shift = wgt; i_in_valid = 1'b1;
    while (!got && t < 50) begin
      got = o_in_ready;
      @(posedge clk); #1;
      t++;
    end
    i_in_valid = 1'b0;
    if (!got) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_check(input int n, input bit bp, input string name);
    int k, cyc;
    bit held, rdy;
    bit pat [4];
    logic [15:0] h0, h1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0; cyc = 0; held = 1'b0; h0 = '0; h1 = '0;
    while (k < n && cyc < 400) begin
      rdy = bp ? pat[cyc % 4] : 1'b1;
      i_out_ready = rdy;
      if (held) begin
        check({name, "_hold_valid"}, 32'(o_out_valid), 32'd1);
        check({name, "_hold_data"}, {o_out_data0, o_out_data1}, {h0, h1});
      end
      if (o_out_valid) begin
        if (rdy) begin
          check({name, "_data0"}, 32'(o_out_data0), 32'(exp0_q[k]));
          check({name, "_data1"}, 32'(o_out_data1), 32'(exp1_q[k]));
          k++;
          held = 1'b0;
        end else begin
          held = 1'b1; h0 = o_out_data0; h1 = o_out_data1;
        end
      end else begin
        held = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    i_out_ready = 1'b0;
    check({name, "_beats"}, 32'(k), 32'(n));
    check({name, "_no_extra"}, 32'(o_out_valid), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (o_busy && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int len, input bit bp, input string name);
    int d0;
    d0 = done_cnt;
    exp0_q = {}; exp1_q = {};
    for (int i = 0; i < len; i++) begin
      exp0_q.push_back(v.e0); exp1_q.push_back(v.e1);
    end
    start_pass(v.k, 7'(len), v.f, 1'b1, v.s, v.b);
    for (int i = 0; i < len; i++) feed_beat(v.cols, v.w);
    drain_check(len, bp, name);
    wait_idle(name);
    check({name, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, t;
    i_rst = 1'b1; i_cfg_start = 1'b0; i_cfg_ksize = '0; i_cfg_len = '0; i_cfg_first = 1'b0;
    i_cfg_last = 1'b0; i_cfg_shift = '0; i_bias = '0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_psum_column = '0; i_wgt_shift = '0;

    add_vec(3, 1, 1, 0, 5, pack6(10, 20, 30, 99, 99, 99), 10, 55);
    add_vec(3, 1, 0, 0, 5, pack6(10, 20, 30, 99, 99, 99), 20, 105);
    add_vec(6, 0, 1, 0, 0, pack6(262143, 262143, 262143, 262143, 262143, 262143), 0, 16'h7FFF);
    add_vec(6, 0, 1, 0, 0, pack6(-262144, -262144, -262144, -262144, -262144, -262144), 0, 16'h8000);
    add_vec(4, 7, 1, 0, 5, pack6(1, 2, 3, 4, 99, 99), 10, 5);
    add_vec(0, 0, 1, 0, -3, pack6(7, 100, 100, 100, 100, 100), 0, 4);
    add_vec(2, 1, 1, 2, 2, pack6(-9, 13, 50, 50, 50, 50), 16'hFFFD, 3);
    add_vec(2, 1, 0, 2, 2, pack6(-9, 13, 50, 50, 50, 50), 16'hFFFA, 6);
    add_vec(7, 3, 1, 0, -128, pack6(1, 2, 3, 4, 5, 6), 6, 16'hFF8F);
    add_vec(3, 3, 1, 0, 1, pack6(1, 2, 4, 8, 8, 8), 7, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_data", {o_out_data0, o_out_data1}, 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // single pass of 4 beats, then the table at len=2
    run_vec(tbl[0], 4, 1'b0, "pass4");
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 2, 1'b0, $sformatf("vec%0d", i));

    // backpressure drain of 8 distinct beats, with a start pulse while busy
    d0 = done_cnt;
    exp0_q = {}; exp1_q = {};
    start_pass(3'd1, 7'd8, 1'b1, 1'b1, 3'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      exp0_q.push_back(16'(100 + i)); exp1_q.push_back(16'd0);
      if (i == 3) begin
        i_cfg_start = 1'b1; i_cfg_len = 7'd1; i_cfg_last = 1'b0;
      end
      feed_beat(pack6(100 + i, 0, 0, 0, 0, 0), 3'd1);
      i_cfg_start = 1'b0;
    end
    drain_check(8, 1'b1, "bp");
    wait_idle("bp");
    check("bp_done_once", 32'(done_cnt - d0), 32'd1);

    // len=0: immediate done, and bank contents untouched
    start_pass(3'd1, 7'd0, 1'b1, 1'b1, 3'd0, 8'd50);
    check("len0_done", 32'(o_done), 32'd1);
    check("len0_busy", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    check("len0_done_drop", 32'(o_done), 32'd0);
    check("len0_idle", 32'(o_busy), 32'd0);
    exp0_q = '{16'd100, 16'd101}; exp1_q = '{16'd0, 16'd0};
    start_pass(3'd1, 7'd2, 1'b0, 1'b1, 3'd0, 8'd0);
    feed_beat('0, 3'd1);
    feed_beat('0, 3'd1);
    drain_check(2, 1'b0, "len0_nowrite");
    wait_idle("len0_nowrite");

    // reset in the middle of a stalled drain
    start_pass(3'd3, 7'd4, 1'b1, 1'b1, 3'd0, 8'd5);
    for (int i = 0; i < 4; i++) feed_beat(tbl[0].cols, 3'd1);
    i_out_ready = 1'b0;
    t = 0;
    while (!o_out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("mid_drain_valid", 32'(o_out_valid), 32'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(o_out_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_ready", 32'(o_in_ready), 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;
    run_vec(tbl[0], 3, 1'b1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_psum_accum.md
Name: pe_psum_accum

Overview:
- Parametrised successor to the fixed 6x6 PE output stage.
- Takes per-column partial sums from a MAC array (COLUMN_NUM columns) and splits them into two output lanes at the weight-shift boundary.
- Accumulates each lane into its own on-chip psum bank, over multiple passes, with bias-or-psum selection, arithmetic shift and saturation.
- After the last pass, streams results out over a valid/ready handshake. Sits between the MAC columns and the layer output buffer.

Parameters:
COLUMN_NUM, 6, number of MAC column psum inputs (2..8)
COL_PSUM_WIDTH, 19, signed width of one column psum
PDATA_WIDTH, 16, signed width of stored/output psum
ACC_WIDTH, 24, signed internal accumulator width (must exceed PDATA_WIDTH+4)
BIAS_WIDTH, 8, signed bias width
DEPTH, 64, entries per psum bank; AW = clog2(DEPTH)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_cfg_start  in  1  pulse: begin a pass (sampled only in IDLE)
i_cfg_ksize  in  3  active kernel columns, 1..COLUMN_NUM
i_cfg_len  in  AW+1  beats in this pass, 0..DEPTH
i_cfg_first  in  1  1: add bias; 0: add stored psum
i_cfg_last  in  1  1: drain the banks after this pass
i_cfg_shift  in  3  psum shift amount
i_bias  in  BIAS_WIDTH  signed bias, added to lane1 only
i_in_valid  in  1  column psum beat valid
o_in_ready  out  1  beat accepted when valid&ready
i_psum_column  in  COLUMN_NUM*COL_PSUM_WIDTH  packed signed column psums, column 0 at the LSBs
i_wgt_shift  in  3  lane split point for this beat
o_out_valid  out  1  drain data valid
i_out_ready  in  1  downstream ready
o_out_data0  out  PDATA_WIDTH  lane0 result
o_out_data1  out  PDATA_WIDTH  lane1 result
o_busy  out  1  FSM not IDLE
o_done  out  1  one-cycle pulse at end of pass / drain

Behaviour:
- Reset: FSM to IDLE; address counters 0; o_in_ready, o_out_valid, o_busy, o_done = 0; o_out_data0/1 = 0. Bank contents are not cleared. Reset mid-pass or mid-drain aborts immediately; pipeline writes in flight are dropped.
- FSM states: IDLE, ACCUM, FLUSH, DRAIN, DONE.
  - IDLE -> ACCUM on i_cfg_start. All cfg fields are latched in this cycle. i_cfg_len == 0 goes IDLE -> DONE directly.
  - i_cfg_start outside IDLE is ignored.
- ACCUM:
  - o_in_ready = 1.
  - Each accepted beat uses wr/rd address = beat counter, 0..len-1.
  - Latched ksize is clamped: 0 is treated as 1; values above COLUMN_NUM become COLUMN_NUM. Columns j >= ksize contribute 0.
  - Lane sums: sum0 = sum of columns j < wgt_shift. sum1 = sum of columns wgt_shift <= j < ksize. If wgt_shift >= ksize, sum0 takes all active columns and sum1 = 0.
  - Sums are sign-extended to ACC_WIDTH.
  - Pipeline:
    - Cycle 0: accept beat, issue bank reads.
    - Cycle 1: read data valid (banks have 1-cycle synchronous read).
      - lane0 = (first ? 0 : rd0<<<shift) + sum0.
      - lane1 = (first ? sext(bias) : rd1<<<shift) + sum1.
      - Each lane result is then >>> shift and saturated to PDATA_WIDTH: max 0x7FFF, min 0x8000 at 16 bits. The result is written to the same address.
  - Addresses are strictly increasing within a pass, so there is no read-after-write hazard.
  - After the len-th accept: ACCUM -> FLUSH. FLUSH holds one cycle for the final write, then goes to DRAIN if last, else DONE.
- DRAIN:
  - Reads addresses 0..len-1 from both banks and presents them on o_out_data0/1 with o_out_valid.
  - A read is issued only if the output register is empty or is being consumed in that cycle. This gives full throughput of 1 beat/cycle when i_out_ready is held high.
  - While valid && !ready, data and valid hold stable.
  - After the final handshake: DRAIN -> DONE.
- DONE: o_done = 1 for one cycle, then IDLE.
- o_busy = 1 in every state except IDLE.

Decomposition:
- Shared package pe_pkg holds:
  - FSM state enum.
  - Saturation limits as functions of PDATA_WIDTH.
  - Mode/ksize constants shared with the PE.
- One natural sub-module: psum_bank, a 1R1W synchronous-read single-bank memory, DEPTH x PDATA_WIDTH, instantiated twice.
- Lane split/sum and saturation stay inline.

Test Plan:
- Single pass: ksize=3, wgt_shift=1, len=4, first=1, last=1, bias=5, shift=0, columns {c0=10, c1=20, c2=30, others 99} -> drain 4 beats, each data0=10, data1=55; o_done pulses once.
- Two passes at the same addresses: first pass as above; second pass first=0, same columns -> drain data0=20, data1=105.
- Saturation: first=1, ksize=6, all columns=+0x3FFFF -> data1=0x7FFF; all columns=-0x40000 -> data1=0x8000.
- Backpressure: drain len=8 with i_out_ready toggled 1,0,0,1… -> data stable while stalled, 8 distinct beats in address order, no loss or duplication.
- Edge cases: len=0 -> o_done one cycle after start, no writes. wgt_shift=7 with ksize=4 -> data1 = bias only. i_cfg_start while busy -> ignored.
- Reset asserted in the middle of DRAIN -> next cycle o_out_valid=0, o_busy=0. A new pass then runs normally.
